exnor_gate: RTL and testbench
=============================

// Module: exnor_gate
//
// PURPOSE
//   Bitwise XNOR (equality) cell: out = a XNOR b, combinational, zero latency.
//   Registered companions give a timing-clean result: out_q, an all-bits-match flag and a
//   matching-bit count. Used as a leaf compare/equality primitive in larger datapaths.
//   Positional order of the first three data ports after clk/rst is a, b, out.
//
// PARAMETERS
//   WIDTH    1   operand width in bits (>=1)
//   CNT_W    $clog2(WIDTH+1)   width of match_cnt (derived localparam, not overridable)
//
// PORTS
//   clk        in   1       single clock; all registers update on rising edge
//   rst        in   1       reset, synchronous, active-high
//   a          in   WIDTH   operand A
//   b          in   WIDTH   operand B
//   out        out  WIDTH   combinational a ~^ b
//   out_q      out  WIDTH   registered a ~^ b
//   match_all  out  1       registered: 1 when every bit of a equals b
//   match_cnt  out  CNT_W   registered: number of bit positions where a == b
//
// BEHAVIOUR
//   - One clock domain; reset synchronous, active-high: sampled only on rising clk.
//   - out: purely combinational, out[i] = ~(a[i] ^ b[i]); follows inputs within the
//     same delta, independent of clk and rst (valid during reset).
//   - out_q, match_all, match_cnt: 1-cycle latency; capture the value of the inputs
//     present at the rising edge, hold until the next edge.
//   - Reset values: out_q = 0, match_all = 0, match_cnt = 0.
//     rst high at an edge overrides capture.
//     First valid registered result appears at the first edge with rst low.
//   - Reset mid-operation: registered outputs clear at the next edge; out is unaffected.
//   - match_all = &(a ~^ b); match_cnt = popcount(a ~^ b), range 0..WIDTH, never wraps.
//   - X/Z on inputs propagates per Verilog semantics; no sanitising.
//   - No handshake and no state machine; every edge with rst low is a capture.
//
// STRUCTURE
//   - No shared package needed; CNT_W is a local derived constant.
//   - One sub-module is natural: popcount (WIDTH -> CNT_W), combinational adder tree,
//     feeding the match_cnt register.
//   - Top: generate loop for the per-bit XNOR, plus a single always @(posedge clk) block
//     with if (rst) priority.
//
// TESTING
//   - Truth table, WIDTH=1, 5 ns steps:
//     (a,b) = 00 -> out=1; 10 -> out=0; 01 -> out=0; 11 -> out=1.
//     Check out immediately each step.
//   - Registered path, WIDTH=1: apply a=1, b=1 before an edge -> after the edge out_q=1,
//     match_all=1, match_cnt=1. Apply a=1, b=0 -> next edge gives 0/0/0.
//   - Reset: hold rst=1 across 2 edges with a=b=1.
//     Expect out_q=0, match_all=0, match_cnt=0, while out=1 throughout.
//     Deassert: values follow on the first edge.
//   - Reset mid-stream: assert rst for one edge between matching vectors.
//     Registered outputs read 0 for exactly that cycle, then resume.
//   - WIDTH=8: a=8'hF0, b=8'hFF -> out=8'hF0, match_cnt=4, match_all=0.
//     a=b=8'hA5 -> out=8'hFF, match_cnt=8, match_all=1.
//   - Exhaustive WIDTH=4: all 256 (a,b) pairs.
//     Compare out against ~(a^b) and match_cnt against a reference popcount, one cycle later.

Source files
------------

// File: rtl/exnor_gate_pkg.sv
// Shared helpers for the exnor_gate equality cell.
package exnor_gate_pkg;

  // Width needed to hold a count of 0..width inclusive.
  function automatic int cntWidth(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/exnor_gate_popcount.sv
// Combinational population count of a WIDTH-bit vector into a CNT_W-bit sum.
module exnor_gate_popcount #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 1
) (
  input  logic [WIDTH-1:0] bits_i,
  output logic [CNT_W-1:0] count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count_o = count_o + CNT_W'(bits_i[i]);
    end
  end

endmodule

// File: rtl/exnor_gate.sv
// Bitwise XNOR equality cell with a combinational result plus registered copy,
// all-bits-match flag and matching-bit count.
module exnor_gate
  import exnor_gate_pkg::*;
#(
  parameter  int WIDTH = 1,
  localparam int CNT_W = cntWidth(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             match_all,
  output logic [CNT_W-1:0] match_cnt
);

  logic [WIDTH-1:0] xnorBits;
  logic [WIDTH-1:0] outReg_d, outReg_q;
  logic             matchAll_d, matchAll_q;
  logic [CNT_W-1:0] matchCnt_d, matchCnt_q;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : gXnor
      assign xnorBits[gi] = ~(a[gi] ^ b[gi]);
    end
  endgenerate

  assign out        = xnorBits;
  assign outReg_d   = xnorBits;
  assign matchAll_d = &xnorBits;

  exnor_gate_popcount #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) uPopcount (
    .bits_i  (xnorBits),
    .count_o (matchCnt_d)
  );

  // Reset takes priority over capture; the combinational out stays live during reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      outReg_q   <= '0;
      matchAll_q <= 1'b0;
      matchCnt_q <= '0;
    end else begin
      outReg_q   <= outReg_d;
      matchAll_q <= matchAll_d;
      matchCnt_q <= matchCnt_d;
    end
  end

  assign out_q     = outReg_q;
  assign match_all = matchAll_q;
  assign match_cnt = matchCnt_q;

endmodule

// File: tb/tb_exnor_gate.sv
// Directed testbench for exnor_gate at WIDTH=1, 8 and 4 sharing one clock and reset.
module tb_exnor_gate;

  logic clk;
  logic rst;

  logic [0:0] a1, b1, out1, outQ1;
  logic       all1;
  logic [0:0] cnt1;

  logic [7:0] a8, b8, out8, outQ8;
  logic       all8;
  logic [3:0] cnt8;

  logic [3:0] a4, b4, out4, outQ4;
  logic       all4;
  logic [2:0] cnt4;

  int assertCount = 0;
  int failCount   = 0;

  exnor_gate #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .out(out1),
    .out_q(outQ1), .match_all(all1), .match_cnt(cnt1)
  );

  exnor_gate #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .out(out8),
    .out_q(outQ8), .match_all(all8), .match_cnt(cnt8)
  );

  exnor_gate #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .out(out4),
    .out_q(outQ4), .match_all(all4), .match_cnt(cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge so registered outputs are stable.
  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic checkReg1(input string tag, input logic [0:0] expQ,
                           input logic expAll, input logic [0:0] expCnt);
    checkOutput({tag, ".out_q"}, 32'(outQ1), 32'(expQ));
    checkOutput({tag, ".match_all"}, 32'(all1), 32'(expAll));
    checkOutput({tag, ".match_cnt"}, 32'(cnt1), 32'(expCnt));
  endtask

  initial begin
    rst = 1'b1;
    a1 = 1'b1; b1 = 1'b1;
    a8 = 8'h00; b8 = 8'h00;
    a4 = 4'h0; b4 = 4'h0;

    // Reset held across two edges with matching inputs
    stepEdge();
    checkReg1("rst_edge1", 1'b0, 1'b0, 1'b0);
    checkOutput("rst_edge1.out", 32'(out1), 32'h1);
    stepEdge();
    checkReg1("rst_edge2", 1'b0, 1'b0, 1'b0);
    checkOutput("rst_edge2.out", 32'(out1), 32'h1);
    checkOutput("rst.out_q8", 32'(outQ8), 32'h0);
    checkOutput("rst.match_cnt4", 32'(cnt4), 32'h0);

    rst = 1'b0;
    stepEdge();
    checkReg1("rst_release", 1'b1, 1'b1, 1'b1);

    // Truth table, combinational path
    a1 = 1'b0; b1 = 1'b0; #1 checkOutput("tt00", 32'(out1), 32'h1); #4;
    a1 = 1'b1; b1 = 1'b0; #1 checkOutput("tt10", 32'(out1), 32'h0); #4;
    a1 = 1'b0; b1 = 1'b1; #1 checkOutput("tt01", 32'(out1), 32'h0); #4;
    a1 = 1'b1; b1 = 1'b1; #1 checkOutput("tt11", 32'(out1), 32'h1); #4;

    // Registered path
    a1 = 1'b1; b1 = 1'b1;
    stepEdge();
    checkReg1("reg11", 1'b1, 1'b1, 1'b1);
    a1 = 1'b1; b1 = 1'b0;
    stepEdge();
    checkReg1("reg10", 1'b0, 1'b0, 1'b0);

    // Single-edge reset between matching vectors
    a1 = 1'b1; b1 = 1'b1;
    stepEdge();
    checkReg1("mid_before", 1'b1, 1'b1, 1'b1);
    rst = 1'b1;
    stepEdge();
    checkReg1("mid_reset", 1'b0, 1'b0, 1'b0);
    checkOutput("mid_reset.out", 32'(out1), 32'h1);
    rst = 1'b0;
    stepEdge();
    checkReg1("mid_after", 1'b1, 1'b1, 1'b1);

    // WIDTH=8 directed vectors
    a8 = 8'hF0; b8 = 8'hFF;
    #1 checkOutput("w8_f0ff.out", 32'(out8), 32'hF0);
    stepEdge();
    checkOutput("w8_f0ff.out_q", 32'(outQ8), 32'hF0);
    checkOutput("w8_f0ff.match_cnt", 32'(cnt8), 32'd4);
    checkOutput("w8_f0ff.match_all", 32'(all8), 32'h0);
    a8 = 8'hA5; b8 = 8'hA5;
    #1 checkOutput("w8_a5a5.out", 32'(out8), 32'hFF);
    stepEdge();
    checkOutput("w8_a5a5.out_q", 32'(outQ8), 32'hFF);
    checkOutput("w8_a5a5.match_cnt", 32'(cnt8), 32'd8);
    checkOutput("w8_a5a5.match_all", 32'(all8), 32'h1);
    a8 = 8'h00; b8 = 8'hFF;
    stepEdge();
    checkOutput("w8_00ff.match_cnt", 32'(cnt8), 32'd0);
    checkOutput("w8_00ff.match_all", 32'(all8), 32'h0);

    // Exhaustive WIDTH=4
    for (int i = 0; i < 256; i++) begin
      logic [3:0] expBits;
      int         expCnt;
      a4 = 4'(i >> 4);
      b4 = 4'(i);
      expBits = 4'h0;
      expCnt  = 0;
      for (int k = 0; k < 4; k++) begin
        if (a4[k] == b4[k]) begin
          expBits[k] = 1'b1;
          expCnt++;
        end
      end
      #1 checkOutput($sformatf("w4_%02h.out", i), 32'(out4), 32'(expBits));
      stepEdge();
      checkOutput($sformatf("w4_%02h.out_q", i), 32'(outQ4), 32'(expBits));
      checkOutput($sformatf("w4_%02h.match_cnt", i), 32'(cnt4), 32'(expCnt));
      checkOutput($sformatf("w4_%02h.match_all", i), 32'(all4), 32'(a4 == b4));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
